// File: rtl/ic_pkg.sv
// Shared definitions for the burst write master: FSM state encoding and a
// constant-evaluable clog2 used to size burst-count and fill-level ports.
package ic_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ic_burst_master_write_if.sv
// Avalon-MM burst write channel between the write master and its slave.
interface ic_burst_master_write_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BC_W   = ic_pkg::clog2(8) + 1
) ();

    logic                  MW_waitrequest;
    logic                  MW_write;
    logic [ADDR_W-1:0]     MW_writeaddress;
    logic [DATA_W-1:0]     MW_writedata;
    logic [BC_W-1:0]       MW_burstcount;
    logic [DATA_W/8-1:0]   MW_byteenable;

    modport master (
        input  MW_waitrequest,
        output MW_write,
        output MW_writeaddress,
        output MW_writedata,
        output MW_burstcount,
        output MW_byteenable
    );

    modport slave (
        output MW_waitrequest,
        input  MW_write,
        input  MW_writeaddress,
        input  MW_writedata,
        input  MW_burstcount,
        input  MW_byteenable
    );

endinterface

// File: rtl/ic_burst_len_calc.sv
// Next burst length: words left capped at BURST_MAX, further limited to the
// FIFO fill level once the image has ended so a partial burst can be flushed.
module ic_burst_len_calc
    import ic_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = 24,
    parameter int BC_W      = clog2(BURST_MAX) + 1
) (
    input  logic [LEN_W-1:0] rem_q,
    input  logic [BC_W-1:0]  ff_usedw,
    input  logic             IC_EndOfImage,
    output logic [BC_W-1:0]  blen
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(BURST_MAX);

    logic [BC_W-1:0] cap;

    always_comb begin
        cap  = (rem_q >= MAX_LEN) ? BC_W'(BURST_MAX) : rem_q[BC_W-1:0];
        blen = cap;
        if (IC_EndOfImage && (ff_usedw < cap)) begin
            blen = ff_usedw;
        end
    end

endmodule

// File: rtl/ic_burst_master_write.sv
// Streams words from a show-ahead FIFO to memory as Avalon-MM write bursts,
// starting at a latched address and stopping after a latched word count.
module ic_burst_master_write
    import ic_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = 24,
    localparam int BC_W     = clog2(BURST_MAX) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MW_start,
    input  logic [ADDR_W-1:0] MW_address,
    input  logic [LEN_W-1:0]  MW_length,
    input  logic              IC_EndOfImage,
    input  logic              ff_empty,
    input  logic [BC_W-1:0]   ff_usedw,
    input  logic [DATA_W-1:0] ff_readdata,
    output logic              ff_readrequest,
    output logic              MW_busy,
    output logic              MW_done,
    ic_burst_master_write_if.master avm
);

    localparam int BYTES = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic [BC_W-1:0]   bcount_q, bcount_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [BC_W-1:0]   blen;
    logic              accept;
    logic              last_beat;

    ic_burst_len_calc #(
        .BURST_MAX (BURST_MAX),
        .LEN_W     (LEN_W),
        .BC_W      (BC_W)
    ) u_len_calc (
        .rem_q         (rem_q),
        .ff_usedw      (ff_usedw),
        .IC_EndOfImage (IC_EndOfImage),
        .blen          (blen)
    );

    assign accept    = avm.MW_write && !avm.MW_waitrequest;
    assign last_beat = ((beat_q + BC_W'(1)) == bcount_q);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        beat_d   = beat_q;
        bcount_d = bcount_q;
        waddr_d  = waddr_q;
        case (state_q)
            ST_IDLE: begin
                if (MW_start) begin
                    state_d = ST_ARM;
                    addr_d  = MW_address;
                    rem_d   = MW_length;
                end
            end
            ST_ARM: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if ((blen != '0) &&
                             ((ff_usedw >= blen) || (IC_EndOfImage && !ff_empty))) begin
                    state_d  = ST_BURST;
                    bcount_d = blen;
                    waddr_d  = addr_q;
                    beat_d   = '0;
                end else if (IC_EndOfImage && ff_empty) begin
                    // Image ended with nothing left to send: finish short.
                    state_d = ST_DONE;
                end
            end
            ST_BURST: begin
                if (accept) begin
                    if (last_beat) begin
                        addr_d  = addr_q + (ADDR_W'(bcount_q) * ADDR_W'(BYTES));
                        rem_d   = rem_q - LEN_W'(bcount_q);
                        beat_d  = '0;
                        state_d = (rem_d == '0) ? ST_DONE : ST_ARM;
                    end else begin
                        beat_d = beat_q + BC_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            beat_q   <= '0;
            bcount_q <= '0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            beat_q   <= beat_d;
            bcount_q <= bcount_d;
            waddr_q  <= waddr_d;
        end
    end

    // Write strobe decodes straight from the state flop so reset drops it at once.
    assign avm.MW_write        = (state_q == ST_BURST);
    assign avm.MW_writeaddress = waddr_q;
    assign avm.MW_burstcount   = bcount_q;
    assign avm.MW_writedata    = ff_readdata;
    assign avm.MW_byteenable   = '1;

    assign ff_readrequest = accept && !ff_empty;
    assign MW_busy        = (state_q != ST_IDLE);
    assign MW_done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ic_burst_master_write.sv
// Randomized bench: a queue-based FIFO and memory-side monitor compared with
// a burst list computed from start address, length and available words.
module tb_ic_burst_master_write;
    import ic_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int BURST_MAX  = 8;
    localparam int LEN_W      = 24;
    localparam int BC_W       = clog2(BURST_MAX) + 1;
    localparam int FIFO_DEPTH = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              MW_start;
    logic [ADDR_W-1:0] MW_address;
    logic [LEN_W-1:0]  MW_length;
    logic              IC_EndOfImage;
    logic              ff_empty;
    logic [BC_W-1:0]   ff_usedw;
    logic [DATA_W-1:0] ff_readdata;
    logic              ff_readrequest;
    logic              MW_busy;
    logic              MW_done;

    ic_burst_master_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BC_W(BC_W)) avm_if ();

    ic_burst_master_write #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_MAX (BURST_MAX),
        .LEN_W     (LEN_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .MW_start       (MW_start),
        .MW_address     (MW_address),
        .MW_length      (MW_length),
        .IC_EndOfImage  (IC_EndOfImage),
        .ff_empty       (ff_empty),
        .ff_usedw       (ff_usedw),
        .ff_readdata    (ff_readdata),
        .ff_readrequest (ff_readrequest),
        .MW_busy        (MW_busy),
        .MW_done        (MW_done),
        .avm            (avm_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fifo[$];
    logic [31:0] pend[$];
    logic [31:0] sent[$];
    logic [31:0] got_data[$];
    logic [31:0] got_addr[$];
    int          got_bc[$];
    logic [31:0] exp_addr[$];
    int          exp_bc[$];

    bit          pop_pending = 1'b0;
    bit          start_req   = 1'b0;
    bit          in_burst    = 1'b0;
    bit          prev_stalled = 1'b0;
    logic [31:0] prev_data   = '0;
    logic [31:0] cur_addr    = '0;
    int          cur_bc      = 0;
    int          beat_in_burst = 0;
    int          stall_pct   = 0;
    int          push_pct    = 0;
    int          done_cnt    = 0;
    int          wr_after_done = 0;
    int          cycle       = 0;
    int          done_cycle  = 0;
    int          start_cycle = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: apply last edge's pop, drive inputs, then observe mid-cycle.
    task automatic tick();
        @(negedge clk);
        if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
        pop_pending = 1'b0;
        if (pend.size() > 0 && fifo.size() < FIFO_DEPTH && $urandom_range(99) < push_pct)
            fifo.push_back(pend.pop_front());
        ff_empty = (fifo.size() == 0);
        ff_usedw = BC_W'(fifo.size());
        if (ff_empty) ff_readdata = 32'hDEAD_BEEF;
        else          ff_readdata = fifo[0];
        avm_if.MW_waitrequest = ($urandom_range(99) < stall_pct);
        MW_start  = start_req;
        start_req = 1'b0;
        #1;
        cycle++;
        if (avm_if.MW_write) begin
            check_val("write_fifo_nonempty", 64'(ff_empty), 64'(0));
            check_val("pop_rule", 64'(ff_readrequest), 64'(!avm_if.MW_waitrequest));
            if (!in_burst) begin
                in_burst      = 1'b1;
                beat_in_burst = 0;
                cur_addr      = avm_if.MW_writeaddress;
                cur_bc        = int'(avm_if.MW_burstcount);
                got_addr.push_back(cur_addr);
                got_bc.push_back(cur_bc);
            end else begin
                check_val("addr_hold", 64'(avm_if.MW_writeaddress), 64'(cur_addr));
                check_val("bc_hold", 64'(avm_if.MW_burstcount), 64'(cur_bc));
            end
            if (prev_stalled) check_val("data_stable", 64'(avm_if.MW_writedata), 64'(prev_data));
            prev_stalled = avm_if.MW_waitrequest;
            prev_data    = avm_if.MW_writedata;
            if (!avm_if.MW_waitrequest) begin
                got_data.push_back(avm_if.MW_writedata);
                beat_in_burst++;
                if (beat_in_burst >= cur_bc) in_burst = 1'b0;
            end
            if (done_cnt > 0) wr_after_done++;
        end else begin
            check_val("pop_idle", 64'(ff_readrequest), 64'(0));
            prev_stalled = 1'b0;
        end
        if (MW_done) begin
            done_cnt++;
            done_cycle = cycle;
        end
        pop_pending = ff_readrequest;
    endtask

    task automatic clear_state();
        fifo.delete(); pend.delete(); sent.delete();
        got_data.delete(); got_addr.delete(); got_bc.delete();
        exp_addr.delete(); exp_bc.delete();
        in_burst = 1'b0; prev_stalled = 1'b0; beat_in_burst = 0;
        done_cnt = 0; wr_after_done = 0; pop_pending = 1'b0;
    endtask

    task automatic run_test(input string name, input logic [31:0] addr, input int len,
                            input int avail, input bit eoi, input int stall, input int push,
                            input bit prefill, input bit seq, input bit spurious);
        int          words;
        int          rem;
        int          b;
        int          n;
        logic [31:0] a;
        logic [31:0] w;
        clear_state();
        for (int i = 0; i < avail; i++) begin
            w = seq ? 32'(i) : $urandom;
            pend.push_back(w);
            sent.push_back(w);
        end
        if (prefill)
            while (pend.size() > 0 && fifo.size() < FIFO_DEPTH) fifo.push_back(pend.pop_front());
        // Expected bursts: the words that will be written, split into BURST_MAX chunks.
        words = (eoi && avail < len) ? avail : len;
        a = addr;
        rem = words;
        while (rem > 0) begin
            b = (rem < BURST_MAX) ? rem : BURST_MAX;
            exp_addr.push_back(a);
            exp_bc.push_back(b);
            a   = a + 32'(b * (DATA_W / 8));
            rem = rem - b;
        end
        stall_pct     = stall;
        push_pct      = push;
        IC_EndOfImage = eoi;
        MW_address    = addr;
        MW_length     = LEN_W'(len);
        start_req     = 1'b1;
        tick();
        start_cycle = cycle;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            if (spurious && n == 3 && MW_busy && !MW_done) begin
                MW_address = 32'h00FF_0000;
                MW_length  = LEN_W'(5);
                start_req  = 1'b1;
            end
            tick();
            n++;
        end
        check_val({name, ":done_seen"}, 64'(done_cnt != 0), 64'(1));
        repeat (3) tick();
        IC_EndOfImage = 1'b0;
        check_val({name, ":done_once"}, 64'(done_cnt), 64'(1));
        check_val({name, ":no_write_after_done"}, 64'(wr_after_done), 64'(0));
        check_val({name, ":busy_idle"}, 64'(MW_busy), 64'(0));
        if (len == 0) check_val({name, ":done_latency"}, 64'(done_cycle - start_cycle), 64'(2));
        check_val({name, ":n_bursts"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_val($sformatf("%s:burst%0d_addr", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
            check_val($sformatf("%s:burst%0d_count", name, i), 64'(got_bc[i]), 64'(exp_bc[i]));
        end
        check_val({name, ":n_beats"}, 64'(got_data.size()), 64'(words));
        for (int i = 0; i < words && i < got_data.size(); i++)
            check_val($sformatf("%s:beat%0d", name, i), 64'(got_data[i]), 64'(sent[i]));
        $display("[TB] %s addr=%08h len=%0d bursts=%0d beats=%0d", name, addr, len,
                 got_addr.size(), got_data.size());
    endtask

    task automatic reset_mid_burst();
        int n;
        clear_state();
        for (int i = 0; i < 8; i++) fifo.push_back(32'(100 + i));
        stall_pct = 0; push_pct = 100; IC_EndOfImage = 1'b0;
        MW_address = 32'h3000; MW_length = LEN_W'(8); start_req = 1'b1;
        tick();
        n = 0;
        while (got_data.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        check_val("rst:reached_beat2", 64'(got_data.size()), 64'(2));
        tick();
        check_val("rst:write_on_beat3", 64'(avm_if.MW_write), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst:write", 64'(avm_if.MW_write), 64'(0));
        check_val("rst:readrequest", 64'(ff_readrequest), 64'(0));
        check_val("rst:busy", 64'(MW_busy), 64'(0));
        check_val("rst:done", 64'(MW_done), 64'(0));
        check_val("rst:burstcount", 64'(avm_if.MW_burstcount), 64'(0));
        check_val("rst:writeaddress", 64'(avm_if.MW_writeaddress), 64'(0));
        pop_pending = 1'b0;
        in_burst    = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check_val("rst:no_done", 64'(done_cnt), 64'(0));
        $display("[TB] reset_mid_burst beats_before_reset=%0d", got_data.size());
        run_test("after_reset", 32'h2000, 8, 8, 1'b0, 0, 100, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        MW_start = 1'b0;
        MW_address = '0;
        MW_length = '0;
        IC_EndOfImage = 1'b0;
        ff_empty = 1'b1;
        ff_usedw = '0;
        ff_readdata = '0;
        avm_if.MW_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset:write", 64'(avm_if.MW_write), 64'(0));
        check_val("reset:busy", 64'(MW_busy), 64'(0));
        check_val("reset:done", 64'(MW_done), 64'(0));
        check_val("reset:readrequest", 64'(ff_readrequest), 64'(0));
        check_val("reset:burstcount", 64'(avm_if.MW_burstcount), 64'(0));
        check_val("reset:writeaddress", 64'(avm_if.MW_writeaddress), 64'(0));
        reset_n = 1'b1;
        tick();
        check_val("idle:busy", 64'(MW_busy), 64'(0));

        run_test("two_bursts",   32'h0000_1000, 16, 16, 1'b0, 0,  100, 1'b1, 1'b1, 1'b0);
        run_test("len11",        32'h0000_0000, 11, 11, 1'b0, 0,  100, 1'b1, 1'b1, 1'b0);
        run_test("stall_seq",    32'h0000_0400, 16, 16, 1'b0, 50, 100, 1'b1, 1'b1, 1'b0);
        run_test("eoi_flush",    32'h0000_0800, 20, 5,  1'b1, 0,  100, 1'b1, 1'b1, 1'b0);
        run_test("len0",         32'h0000_0040, 0,  0,  1'b0, 0,  100, 1'b1, 1'b1, 1'b0);
        run_test("addr_wrap",    32'hFFFF_FFF0, 16, 16, 1'b0, 20, 100, 1'b1, 1'b0, 1'b0);
        run_test("ignore_start", 32'h0000_5000, 12, 12, 1'b0, 30, 60,  1'b0, 1'b0, 1'b1);
        reset_mid_burst();

        for (int t = 0; t < 8; t++) begin
            logic [31:0] r_addr;
            int          r_len;
            int          r_avail;
            bit          r_eoi;
            r_addr  = $urandom & 32'hFFFF_FFFC;
            r_len   = int'($urandom_range(1, 40));
            r_eoi   = ($urandom_range(0, 3) == 0);
            r_avail = r_eoi ? int'($urandom_range(1, 15)) : r_len;
            run_test($sformatf("rand%0d", t), r_addr, r_len, r_avail, r_eoi,
                     int'($urandom_range(0, 60)),
                     r_eoi ? 100 : int'($urandom_range(20, 100)),
                     r_eoi ? 1'b1 : 1'($urandom_range(0, 1)),
                     1'b0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
